// File: rtl/mc_control_unit.sv
// mc_control_unit - multi-cycle control sequencer for the RV32I core.
//
// Steps each instruction through FETCH, DECODE, EXEC, MEM and WB. Both
// instruction fetch and data access go through one shared memory port with
// a req/ready handshake. Every access has a timeout, and the block keeps a
// count of retired instructions.
//
// Optional feature: define CTRL_ECALL_HALT_EN to park the core in HALT on a
// SYSTEM instruction. When the macro is not defined, SYSTEM retires as a NOP.
//
// Parameters: OPC_W (opcode width), TIMEOUT (max wait cycles per access, >=2),
//             RET_W (retired-instruction counter width)
// Inputs : clk, rst (async, active-high), opcode (inst[6:2]), mem_ready
// Outputs: mem_req, mem_we, mem_sel, ir_write, pc_write, Branch[1:0],
//          ALUOp[2:0], ALUSrc, MemtoReg, RegWrite, retire, mem_err,
//          illegal_op, halted, retired_cnt[RET_W-1:0]
module mc_control_unit #(
    parameter int OPC_W   = 5,
    parameter int TIMEOUT = 16,
    parameter int RET_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [OPC_W-1:0] opcode,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_sel,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       Branch,
    output logic [2:0]       ALUOp,
    output logic             ALUSrc,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             retire,
    output logic             mem_err,
    output logic             illegal_op,
    output logic             halted,
    output logic [RET_W-1:0] retired_cnt
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [OPC_W-1:0] OP_R      = OPC_W'(5'b01100);
    localparam logic [OPC_W-1:0] OP_LOAD   = OPC_W'(5'b00000);
    localparam logic [OPC_W-1:0] OP_STORE  = OPC_W'(5'b01000);
    localparam logic [OPC_W-1:0] OP_BRANCH = OPC_W'(5'b11000);
    localparam logic [OPC_W-1:0] OP_JALR   = OPC_W'(5'b11001);
    localparam logic [OPC_W-1:0] OP_JAL    = OPC_W'(5'b11011);
    localparam logic [OPC_W-1:0] OP_ARITHI = OPC_W'(5'b00100);
    localparam logic [OPC_W-1:0] OP_AUIPC  = OPC_W'(5'b00101);
    localparam logic [OPC_W-1:0] OP_LUI    = OPC_W'(5'b01101);
    localparam logic [OPC_W-1:0] OP_SYSTEM = OPC_W'(5'b11100);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [OPC_W-1:0]  r_op;
    logic [CNT_W-1:0]  r_tmo;
    logic [RET_W-1:0]  r_ret_cnt;
    logic              w_wait;
    logic              w_tmo;

    function automatic logic f_known(input logic [OPC_W-1:0] op);
        case (op)
            OP_R, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR, OP_JAL,
            OP_ARITHI, OP_AUIPC, OP_LUI, OP_SYSTEM: f_known = 1'b1;
            default:                                f_known = 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] f_aluop(input logic [OPC_W-1:0] op);
        case (op)
            OP_R:      f_aluop = 3'b000;
            OP_ARITHI: f_aluop = 3'b001;
            OP_BRANCH: f_aluop = 3'b011;
            OP_LUI:    f_aluop = 3'b111;
            OP_SYSTEM: f_aluop = 3'b101;
            OP_LOAD, OP_STORE, OP_JAL, OP_JALR, OP_AUIPC: f_aluop = 3'b010;
            default:   f_aluop = 3'b110;
        endcase
    endfunction

    function automatic logic f_alusrc(input logic [OPC_W-1:0] op);
        case (op)
            OP_R, OP_BRANCH, OP_SYSTEM: f_alusrc = 1'b0;
            default:                    f_alusrc = 1'b1;
        endcase
    endfunction

    // A memory wait cycle is one spent in FETCH/MEM without mem_ready; the
    // last permitted wait cycle raises the timeout unless ready arrives.
    assign w_wait = ((r_state == S_FETCH) || (r_state == S_MEM)) && !mem_ready;
    assign w_tmo  = w_wait && (r_tmo == TMO_LAST);
    assign retired_cnt = r_ret_cnt;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   w_next = S_FETCH;
            S_FETCH:  w_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: w_next = f_known(opcode) ? S_EXEC : S_FETCH;
            S_EXEC: begin
                case (r_op)
                    OP_BRANCH:          w_next = S_FETCH;
                    OP_LOAD, OP_STORE:  w_next = S_MEM;
`ifdef CTRL_ECALL_HALT_EN
                    OP_SYSTEM:          w_next = S_HALT;
`else
                    OP_SYSTEM:          w_next = S_FETCH;
`endif
                    default:            w_next = S_WB;
                endcase
            end
            S_MEM: begin
                if (mem_ready) begin
                    w_next = (r_op == OP_STORE) ? S_FETCH : S_WB;
                end else if (w_tmo) begin
                    w_next = S_FETCH;
                end else begin
                    w_next = S_MEM;
                end
            end
            S_WB:     w_next = S_FETCH;
            S_HALT:   w_next = S_HALT;
            default:  w_next = S_IDLE;
        endcase
    end

    // Output decode from state and op_q (plus mem_ready for handshake pulses).
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_sel    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        Branch     = 2'b00;
        ALUOp      = 3'b000;
        ALUSrc     = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        retire     = 1'b0;
        mem_err    = 1'b0;
        illegal_op = 1'b0;
        halted     = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_req  = 1'b1;
                ir_write = mem_ready;
                mem_err  = w_tmo;
            end
            S_DECODE: begin
                // Unknown opcodes retire as a NOP so the PC still advances.
                if (!f_known(opcode)) begin
                    illegal_op = 1'b1;
                    pc_write   = 1'b1;
                    retire     = 1'b1;
                end else begin
                    illegal_op = 1'b0;
                end
            end
            S_EXEC: begin
                ALUOp  = f_aluop(r_op);
                ALUSrc = f_alusrc(r_op);
                case (r_op)
                    OP_BRANCH: begin
                        Branch   = 2'b01;
                        pc_write = 1'b1;
                        retire   = 1'b1;
                    end
                    OP_SYSTEM: begin
                        // With halt enabled the PC stays on the SYSTEM instruction.
`ifdef CTRL_ECALL_HALT_EN
                        retire   = 1'b1;
`else
                        pc_write = 1'b1;
                        retire   = 1'b1;
`endif
                    end
                    default: begin
                        retire = 1'b0;
                    end
                endcase
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_sel = 1'b1;
                mem_we  = (r_op == OP_STORE);
                ALUOp   = f_aluop(r_op);
                ALUSrc  = f_alusrc(r_op);
                mem_err = w_tmo;
                if (mem_ready && (r_op == OP_STORE)) begin
                    pc_write = 1'b1;
                    retire   = 1'b1;
                end else begin
                    retire   = 1'b0;
                end
            end
            S_WB: begin
                ALUOp    = f_aluop(r_op);
                ALUSrc   = f_alusrc(r_op);
                RegWrite = 1'b1;
                MemtoReg = (r_op == OP_LOAD);
                pc_write = 1'b1;
                retire   = 1'b1;
                Branch   = ((r_op == OP_JAL) || (r_op == OP_JALR)) ? 2'b10 : 2'b00;
            end
            S_HALT: begin
`ifdef CTRL_ECALL_HALT_EN
                halted = 1'b1;
`else
                halted = 1'b0;
`endif
            end
            default: begin
                halted = 1'b0;
            end
        endcase
    end

    // Capture the opcode as the FSM enters EXEC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op <= '0;
        end else if ((r_state == S_DECODE) && (w_next == S_EXEC)) begin
            r_op <= opcode;
        end else begin
            r_op <= r_op;
        end
    end

    // Per-access wait counter: cleared on any state change or timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tmo <= '0;
        end else if (w_tmo || (w_next != r_state)) begin
            r_tmo <= '0;
        end else if (w_wait) begin
            r_tmo <= r_tmo + CNT_W'(1);
        end else begin
            r_tmo <= r_tmo;
        end
    end

    // Retired-instruction counter, wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ret_cnt <= '0;
        end else if (retire) begin
            r_ret_cnt <= r_ret_cnt + RET_W'(1);
        end else begin
            r_ret_cnt <= r_ret_cnt;
        end
    end

endmodule

// File: doc/mc_control_unit.md
# mc_control_unit

Multi-cycle control sequencer for the RV32I core: replaces the single-cycle opcode decoder with a state machine that steps each instruction through FETCH, DECODE, EXEC, MEM and WB over several clocks. The core fetches and accesses data through one shared memory port using a req/ready handshake, with a per-access timeout. The block drives the datapath control signals per state and keeps a retired-instruction counter. It sits between the instruction register and the datapath muxes, ALU control and register file.

## Interface
- `OPC_W`, 5 — opcode field width (inst[6:2])
- `TIMEOUT`, 16 — max wait cycles per memory access, ≥2
- `RET_W`, 32 — retired-instruction counter width
- `clk` input 1 — clock, rising edge
- `rst` input 1 — asynchronous, active-high reset
- `opcode` input OPC_W — inst[6:2] from the instruction register; valid from DECODE onward
- `mem_ready` input 1 — memory completes the access this cycle
- `mem_req` output 1 — memory access request
- `mem_we` output 1 — write request (store)
- `mem_sel` output 1 — address source: 0 = PC, 1 = ALU result
- `ir_write` output 1 — load the instruction register
- `pc_write` output 1 — update the PC
- `Branch` output 2 — next-PC select: 00 = PC+4, 01 = branch target, 10 = jump target
- `ALUOp` output 3 — ALU control class
- `ALUSrc`, `MemtoReg`, `RegWrite` output 1 each — datapath mux/enable controls
- `retire` output 1 — one-cycle pulse when an instruction completes
- `mem_err` output 1 — one-cycle pulse on memory timeout
- `illegal_op` output 1 — one-cycle pulse in DECODE when the opcode is unknown
- `halted` output 1 — the core is parked by a SYSTEM instruction
- `retired_cnt` output RET_W — count of retired instructions

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- Outputs are Moore, decoded from the state and `op_q`. `op_q` is the opcode registered on entry to EXEC.
- Opcode set: R 01100, LOAD 00000, STORE 01000, BRANCH 11000, JALR 11001, JAL 11011, ARITH_I 00100, AUIPC 00101, LUI 01101, SYSTEM 11100.
- ALUOp by opcode:
  - R 000, ARITH_I 001, BRANCH 011, LUI 111, SYSTEM 101.
  - LOAD, STORE, JAL, JALR and AUIPC use 010.
  - Unknown opcodes use 110.
- ALUSrc = 1 for every class except R, BRANCH and SYSTEM.
- IDLE: all outputs 0; next state FETCH.
- FETCH: `mem_req`=1, `mem_sel`=0; `ir_write`=`mem_ready`. Move to DECODE when `mem_ready`=1.
- DECODE: control outputs 0. An unknown opcode pulses `illegal_op`, retires as a NOP (`pc_write`=1, `Branch`=00) and returns to FETCH. Any other opcode moves to EXEC.
- EXEC: drives ALUOp and ALUSrc.
  - BRANCH: `Branch`=01, `pc_write`=1, retire, then FETCH.
  - LOAD and STORE: go to MEM.
  - SYSTEM: see Configuration.
  - All others: go to WB.
- MEM: `mem_req`=1, `mem_sel`=1, `mem_we`=(op is STORE); ALUOp and ALUSrc are held.
  - On `mem_ready`, LOAD goes to WB.
  - On `mem_ready`, STORE retires (`pc_write`=1, `Branch`=00) and goes to FETCH.
- WB: `RegWrite`=1, `MemtoReg`=(op is LOAD), `pc_write`=1, retire, then FETCH.
  - `Branch` is 10 for JAL/JALR (the link register is written) and 00 otherwise.
- Retire: `retire` pulses and `retired_cnt` increments by 1, wrapping modulo 2^RET_W.
- Timeout counter: counts cycles in FETCH/MEM where `mem_ready`=0 and clears on every state change.
  - When the count reaches TIMEOUT-1 with `mem_ready`=0, `mem_err` pulses and the FSM goes to FETCH.
  - No `pc_write` and no retire occur, so the same PC is refetched.
  - If `mem_ready`=1 in that same cycle, the access completes normally and no error is raised.

## Timing
- Reset, asynchronous: state IDLE, `op_q`=0, timeout counter 0, `retired_cnt`=0, every output 0.
- Reset asserted mid-instruction aborts it immediately; no retire occurs.
- Zero-wait memory (`mem_ready`=1 in the request cycle), FETCH to retire:
  - BRANCH: 3 cycles.
  - R, ARITH_I, AUIPC, LUI, JAL, JALR, STORE: 4 cycles.
  - LOAD: 5 cycles.
- Each wait cycle adds 1 to the FETCH or MEM state.
- The first FETCH follows reset release by 1 cycle (IDLE).
- `retire`, `mem_err` and `illegal_op` are each high for exactly one cycle.

## Configuration
- `CTRL_ECALL_HALT_EN` defined:
  - SYSTEM in EXEC moves to HALT.
  - HALT drives `halted`=1 with all other control outputs 0, and stays there until reset.
  - The SYSTEM instruction is retired on entry to HALT.
- Not defined:
  - SYSTEM executes as a NOP: `pc_write`=1, `Branch`=00, retire, then FETCH.
  - `halted` is tied to 0.

## Test plan
- Reset release, R opcode 01100, `mem_ready` held 1 → IDLE, FETCH, DECODE, EXEC, WB; `RegWrite`=1 in cycle 5; `retire` in cycle 5; `retired_cnt`=1.
- LOAD 00000 with `mem_ready` delayed 2 cycles in MEM → 7 cycles to retire; `MemtoReg`=1 and ALUOp=010 in WB.
- `mem_ready` held 0 during FETCH with TIMEOUT=16 → `mem_err` pulses at wait cycle 16, FETCH re-entered, `retired_cnt` unchanged; `mem_ready` arriving on cycle 16 instead → no error.
- Opcode 11111 → `illegal_op` pulse in DECODE, `pc_write`=1, `Branch`=00, `retired_cnt`+1.
- SYSTEM 11100 → with the macro defined, `halted`=1 and it persists for 100 cycles, then clears on `rst`; without the macro, it retires in 3 cycles and FETCH continues.
- RET_W=4, run 16 BRANCH instructions → `retired_cnt` wraps from 15 to 0.
